// File: rtl/lhd_sched_pkg.sv
// lhd_sched_pkg: shared state encoding, default parameters and id sizing for lhd_hash_scheduler
package lhd_sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CRST, S_FEED, S_GAP, S_WAIT, S_RESP} sched_state_t;
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_LEN_W       = 16;
    localparam int DEF_RST_CYC     = 2;
    localparam int DEF_GAP_CYC     = 1;
    localparam int DEF_TIMEOUT_CYC = 1024;
    function automatic int ID_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/lhd_hash_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot pick of the first requester at or after the pointer, cyclically
module rr_arbiter
    import lhd_sched_pkg::*;
#(
    parameter int  N  = DEF_N_REQ,
    localparam int IW = ID_W(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] id_o
);
    // Scan farthest-first so the candidate nearest the pointer overwrites the rest
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                gnt_o = '0;
                gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
                id_o = IW'((int'(ptr_i) + k) % N);
            end
        end
    end
endmodule

// File: rtl/lhd_hash_scheduler.sv
// lhd_hash_scheduler: round-robin sharing of one lightHashDES core between N_REQ byte-stream requesters
module lhd_hash_scheduler
    import lhd_sched_pkg::*;
#(
    parameter int  N_REQ       = DEF_N_REQ,
    parameter int  LEN_W       = DEF_LEN_W,
    parameter int  RST_CYC     = DEF_RST_CYC,
    parameter int  GAP_CYC     = DEF_GAP_CYC,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int IW          = ID_W(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*8-1:0]     in_data,
    output logic [N_REQ-1:0]       in_ready,
    output logic [N_REQ-1:0]       gnt,
    output logic                   core_rst_n,
    output logic                   core_M_valid,
    output logic [7:0]             core_M,
    output logic [63:0]            core_input_length,
    input  logic                   core_hash_ready,
    input  logic [31:0]            core_digest,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IW-1:0]          rsp_id,
    output logic [31:0]            rsp_digest,
    output logic                   rsp_err,
    output logic                   busy
);
    localparam int TW = $clog2(TIMEOUT_CYC + RST_CYC + GAP_CYC + 1) + 1;

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    ptr_q, id_q, arb_id;
    logic [N_REQ-1:0] gnt_q, arb_gnt;
    logic [LEN_W-1:0] len_q, cnt_q, cnt_inc;
    logic [TW-1:0]    tmr_q;
    logic [7:0]       core_m_q;
    logic [31:0]      rsp_digest_q;
    logic             core_rst_n_q, core_m_valid_q, rsp_err_q, byte_acc;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    assign byte_acc          = (state_q == S_FEED) && in_valid[id_q];
    assign cnt_inc           = cnt_q + LEN_W'(1);
    assign gnt               = gnt_q;
    assign core_rst_n        = core_rst_n_q;
    assign core_M_valid      = core_m_valid_q;
    assign core_M            = core_m_q;
    assign core_input_length = 64'(len_q);
    assign rsp_id            = id_q;
    assign rsp_digest        = rsp_digest_q;
    assign rsp_err           = rsp_err_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Session sequencing; a zero-length message skips straight from core reset to waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (|req) state_d = S_CRST;
            S_CRST: if (tmr_q == TW'(RST_CYC - 1)) state_d = (len_q == '0) ? S_WAIT : S_FEED;
            S_FEED: if (byte_acc) state_d = (GAP_CYC > 0) ? S_GAP : ((cnt_inc == len_q) ? S_WAIT : S_FEED);
            S_GAP:  if (tmr_q == TW'(GAP_CYC - 1)) state_d = (cnt_q == len_q) ? S_WAIT : S_FEED;
            S_WAIT: if (core_hash_ready || tmr_q == TW'(TIMEOUT_CYC - 1)) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded straight from the current state
    always_comb begin
        in_ready  = (state_q == S_FEED) ? gnt_q : '0;
        rsp_valid = state_q == S_RESP;
        busy      = state_q != S_IDLE;
    end

    // Session datapath: grant latch, per-state timer, byte pacing and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q          <= '0;
            id_q           <= '0;
            gnt_q          <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            tmr_q          <= '0;
            core_rst_n_q   <= 1'b0;
            core_m_valid_q <= 1'b0;
            core_m_q       <= '0;
            rsp_digest_q   <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            core_m_valid_q <= byte_acc;
            tmr_q          <= (state_d != state_q) ? '0 : tmr_q + TW'(1);
            if (state_q == S_IDLE && |req) begin
                gnt_q        <= arb_gnt;
                id_q         <= arb_id;
                len_q        <= req_len[LEN_W*arb_id +: LEN_W];
                cnt_q        <= '0;
                core_rst_n_q <= 1'b0;
            end
            if (state_q == S_CRST && state_d != S_CRST) core_rst_n_q <= 1'b1;
            if (byte_acc) begin
                core_m_q <= in_data[8*id_q +: 8];
                cnt_q    <= cnt_inc;
            end
            if (state_q == S_WAIT && state_d == S_RESP) begin
                rsp_digest_q <= core_hash_ready ? core_digest : '0;
                rsp_err_q    <= !core_hash_ready;
            end
            if (state_q == S_RESP && rsp_ready) begin
                gnt_q <= '0;
                ptr_q <= (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_lhd_hash_scheduler.sv
// tb_lhd_hash_scheduler: scoreboard bench with a behavioural hash core for lhd_hash_scheduler
module tb_lhd_hash_scheduler;
    localparam int N     = 4;
    localparam int LEN_W = 16;
    localparam int RC    = 2;
    localparam int GC    = 1;
    localparam int TO    = 16;
    localparam int IW    = 2;

    typedef struct {
        int          id;
        int          len;
        logic [31:0] dig;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]       req;
    logic [N*LEN_W-1:0] req_len;
    logic [N-1:0]       in_valid;
    logic [N*8-1:0]     in_data;
    logic [N-1:0]       in_ready, gnt;
    logic               core_rst_n, core_M_valid, core_hash_ready;
    logic [7:0]         core_M;
    logic [63:0]        core_input_length;
    logic [31:0]        core_digest, rsp_digest;
    logic               rsp_valid, rsp_ready, rsp_err, busy;
    logic [IW-1:0]      rsp_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -100;
    logic bubble_en, never_rdy, rst_seen;
    logic [7:0] prev_m;
    logic [7:0] feed_q [N][$];
    logic [7:0] exp_byte [$];
    rsp_t exp_rsp [$];
    logic [31:0] m_acc;
    int m_cnt, m_tmr;

    lhd_hash_scheduler #(.N_REQ(N), .LEN_W(LEN_W), .RST_CYC(RC), .GAP_CYC(GC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .gnt(gnt), .core_rst_n(core_rst_n), .core_M_valid(core_M_valid),
        .core_M(core_M), .core_input_length(core_input_length), .core_hash_ready(core_hash_ready),
        .core_digest(core_digest), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_digest(rsp_digest), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [7:0] b);
        return {a[26:0], a[31:27]} ^ (32'h9E3779B9 * {24'h0, b} + 32'h0000_0101);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rst_seen <= rst;
        for (int i = 0; i < N; i++)
            if (in_valid[i] === 1'b1 && in_ready[i] === 1'b1 && feed_q[i].size() > 0) void'(feed_q[i].pop_front());
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            in_valid[i] = feed_q[i].size() > 0 && (!bubble_en || $urandom_range(0, 2) != 0);
            in_data[8*i +: 8] = (feed_q[i].size() > 0) ? feed_q[i][0] : 8'h00;
        end
    end

    // Behavioural core: digest over the received bytes, ready 5 cycles after the last one
    always @(posedge clk) begin
        if (rst || core_rst_n !== 1'b1) begin
            m_acc = 32'hA5A5_0000 ^ core_input_length[31:0];
            m_cnt = 0;
            m_tmr = 0;
            core_hash_ready <= 1'b0;
            core_digest <= 32'h0;
        end else begin
            if (core_M_valid) begin
                m_acc = mix(m_acc, core_M);
                m_cnt++;
            end
            if (64'(m_cnt) == core_input_length && !never_rdy && m_tmr < 5) begin
                m_tmr++;
                if (m_tmr == 5) begin
                    core_hash_ready <= 1'b1;
                    core_digest <= m_acc;
                end
            end
        end
    end

    // Byte scoreboard, pulse spacing, grant exclusivity and core_M hold
    always @(negedge clk) begin
        if (rst_seen === 1'b0) begin
            checks++;
            if ((in_ready & ~gnt) !== '0) begin
                errors++;
                $display("FAIL in_ready_excl: in_ready=%b gnt=%b, required no ready outside grant", in_ready, gnt);
            end
            if (core_M_valid) begin
                pulse_cnt++;
                checks++;
                if (exp_byte.size() == 0) begin
                    errors++;
                    $display("FAIL byte_extra: got core_M=%h, required no pulse", core_M);
                end else if (core_M !== exp_byte[0]) begin
                    errors++;
                    $display("FAIL byte_order: got core_M=%h, required %h", core_M, exp_byte[0]);
                end
                if (exp_byte.size() > 0) void'(exp_byte.pop_front());
                checks++;
                if (cyc - last_pulse_cyc < GC + 1) begin
                    errors++;
                    $display("FAIL byte_spacing: got %0d cycles, required >= %0d", cyc - last_pulse_cyc, GC + 1);
                end
                last_pulse_cyc = cyc;
            end else if (core_M !== prev_m) begin
                checks++;
                errors++;
                $display("FAIL core_M_hold: got %h, required %h", core_M, prev_m);
            end
        end
        prev_m = core_M;
    end

    task automatic launch(input int id, input int len, input logic [7:0] base);
        rsp_t e;
        logic [31:0] d;
        logic [7:0] b;
        d = 32'hA5A5_0000 ^ 32'(len);
        for (int k = 0; k < len; k++) begin
            b = base + 8'(k * 7);
            feed_q[id].push_back(b);
            exp_byte.push_back(b);
            d = mix(d, b);
        end
        e.id = id;
        e.len = len;
        e.dig = never_rdy ? 32'h0 : d;
        e.err = never_rdy;
        exp_rsp.push_back(e);
        req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
        req[id] = 1'b1;
    endtask

    task automatic wait_rsps(input int n);
        rsp_t e;
        int got, t, base;
        logic [N-1:0] prev;
        got = 0;
        t = 0;
        base = pulse_cnt;
        prev = '0;
        while (got < n && t < 3000) begin
            @(negedge clk);
            t++;
            if (gnt != '0 && gnt != prev) base = pulse_cnt;
            prev = gnt;
            req &= ~gnt;
            if (rsp_valid && !rsp_ready) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_extra: got id=%0d, required no response", rsp_id);
                end else begin
                    e = exp_rsp.pop_front();
                    if (rsp_id !== IW'(e.id) || gnt !== N'(1 << e.id) || rsp_digest !== e.dig ||
                        rsp_err !== e.err || pulse_cnt - base != e.len)
                    begin
                        errors++;
                        $display("FAIL rsp: got id=%0d gnt=%b dig=%h err=%b pulses=%0d, required id=%0d dig=%h err=%b pulses=%0d",
                                 rsp_id, gnt, rsp_digest, rsp_err, pulse_cnt - base, e.id, e.dig, e.err, e.len);
                    end
                end
                got++;
                rsp_ready = 1'b1;
            end else rsp_ready = 1'b0;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL rsp_wait: got %0d responses, required %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, in_ready, core_rst_n, core_M_valid, core_M, core_input_length, rsp_valid, rsp_id, rsp_digest, rsp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b rdy=%b rst_n=%b mv=%b m=%h len=%h rv=%b id=%h dig=%h err=%b busy=%b, required all 0",
                     gnt, in_ready, core_rst_n, core_M_valid, core_M, core_input_length, rsp_valid, rsp_id, rsp_digest, rsp_err, busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_len0();
        int lo;
        launch(0, 0, 8'h00);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || core_rst_n !== 1'b0 || core_input_length !== 64'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL len0_grant: gnt=%b rst_n=%b len=%0d busy=%b, required 0001 0 0 1", gnt, core_rst_n, core_input_length, busy);
        end
        req = '0;
        lo = 0;
        while (core_rst_n !== 1'b1 && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        checks++;
        if (lo != RC) begin
            errors++;
            $display("FAIL len0_core_rst: got %0d low cycles, required %0d", lo, RC);
        end
        wait_rsps(1);
    endtask

    task automatic test_len1();
        launch(1, 1, 8'h41);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || core_input_length !== 64'd1) begin
            errors++;
            $display("FAIL len1_grant: gnt=%b len=%0d, required 0010 1", gnt, core_input_length);
        end
        wait_rsps(1);
    endtask

    task automatic test_arbitration();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        launch(0, 1, 8'h11);
        launch(2, 2, 8'h22);
        wait_rsps(2);
        launch(3, 1, 8'h33);
        launch(0, 2, 8'h44);
        launch(1, 1, 8'h55);
        launch(2, 3, 8'h66);
        wait_rsps(4);
    endtask

    task automatic test_bubbles();
        bubble_en = 1'b1;
        launch(2, 5, 8'h60);
        wait_rsps(1);
        bubble_en = 1'b0;
    endtask

    task automatic test_timeout();
        rsp_t e;
        int t;
        never_rdy = 1'b1;
        launch(1, 2, 8'hC0);
        t = 0;
        while (rsp_valid !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
            req &= ~gnt;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: rsp_valid=%b after %0d cycles, required 1", rsp_valid, t);
        end
        e = exp_rsp.pop_front();
        checks++;
        if (cyc - last_pulse_cyc < TO || cyc - last_pulse_cyc > TO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles after last byte, required %0d..%0d", cyc - last_pulse_cyc, TO, TO + 2);
        end
        checks++;
        if (rsp_id !== IW'(e.id) || rsp_digest !== e.dig || rsp_err !== e.err) begin
            errors++;
            $display("FAIL timeout_value: id=%0d dig=%h err=%b, required id=%0d dig=%h err=%b", rsp_id, rsp_digest, rsp_err, e.id, e.dig, e.err);
        end
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'(e.id) || rsp_digest !== e.dig || rsp_err !== e.err) begin
                errors++;
                $display("FAIL timeout_hold: rv=%b id=%0d dig=%h err=%b, required 1 %0d %h %b", rsp_valid, rsp_id, rsp_digest, rsp_err, e.id, e.dig, e.err);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: busy=%b gnt=%b rv=%b, required 0 0000 0", busy, gnt, rsp_valid);
        end
        never_rdy = 1'b0;
    endtask

    task automatic test_rst_mid();
        int p0, t;
        launch(3, 8, 8'h80);
        p0 = pulse_cnt;
        t = 0;
        while (pulse_cnt - p0 < 3 && t < 200) begin
            @(negedge clk);
            t++;
            req &= ~gnt;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({gnt, in_ready, core_rst_n, core_M_valid, core_M, core_input_length, rsp_valid, rsp_id, rsp_digest, rsp_err, busy} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: gnt=%b rdy=%b rst_n=%b mv=%b m=%h len=%h rv=%b id=%h busy=%b, required all 0",
                     gnt, in_ready, core_rst_n, core_M_valid, core_M, core_input_length, rsp_valid, rsp_id, busy);
        end
        feed_q[3].delete();
        exp_byte.delete();
        exp_rsp.delete();
        req = '0;
        rst = 1'b0;
        launch(0, 3, 8'h33);
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_ptr: gnt=%b, required 0001", gnt);
        end
        req = '0;
        wait_rsps(1);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_len = '0;
        rsp_ready = 1'b0;
        bubble_en = 1'b0;
        never_rdy = 1'b0;
        test_reset();
        test_len0();
        test_len1();
        test_arbitration();
        test_bubbles();
        test_timeout();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
